// File: rtl/fx2_in_pkg.sv
// ---------------------------------------------------------------------------
// fx2_in_pkg
// Shared types and constants for the FX2 slave-FIFO stream-IN writer.
//   state_t      : controller states (IDLE, WRITE, DRAIN, PKTEND)
//   MODE_*       : data-source selectors on the mode input
//   EP2..EP8     : FX2 FIFOADR codes for the four endpoints
//   norm_mode()  : folds the reserved mode code onto the counter source
// ---------------------------------------------------------------------------
package fx2_in_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    DRAIN  = 2'd2,
    PKTEND = 2'd3
  } state_t;

  localparam logic [1:0] MODE_CNT = 2'd0;
  localparam logic [1:0] MODE_EXT = 2'd1;
  localparam logic [1:0] MODE_PAT = 2'd2;

  localparam logic [1:0] EP2 = 2'b00;
  localparam logic [1:0] EP4 = 2'b01;
  localparam logic [1:0] EP6 = 2'b10;
  localparam logic [1:0] EP8 = 2'b11;

  // Mode 3 is reserved and behaves exactly like the counter source.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_CNT : m;
  endfunction

endpackage

// File: rtl/fx2_sync2.sv
// ---------------------------------------------------------------------------
// fx2_sync2
// Two-flop level synchronizer for a slow asynchronous control input.
//   fx2_ifclk : destination clock
//   reset_n   : asynchronous active-low reset; both flops load RST_VAL
//   async_in  : asynchronous level
//   sync_out  : async_in re-timed to fx2_ifclk (two-cycle latency)
// ---------------------------------------------------------------------------
module fx2_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic fx2_ifclk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // NOTE: flop chains use non-blocking assignments so every stage samples
  // the value from before the edge; blocking here would collapse the chain.
  always_ff @(posedge fx2_ifclk or negedge reset_n) begin
    if (!reset_n) begin
      meta     <= RST_VAL;
      sync_out <= RST_VAL;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/fx2_stream_in_ctrl.sv
// ---------------------------------------------------------------------------
// fx2_stream_in_ctrl
// FX2 slave-FIFO stream-IN writer. Pushes words into one endpoint FIFO,
// framed into packets of PKT_WORDS words, from an internal counter, a fixed
// pattern, or an external valid/ready source. Runs while tx_trigger is low.
//
// Optional feature macro: FX2_IN_SHORT_PKT_EN
//   defined   : stopping mid-packet commits a short packet via fx2_pkt_end
//   undefined : stopping mid-packet drains the packet to full length;
//               fx2_pkt_end is tied high
//
// Ports:
//   fx2_ifclk   in   interface clock (only clock)
//   reset_n     in   asynchronous active-low reset
//   tx_trigger  in   active-low run request, asynchronous
//   mode        in   0 counter, 1 external, 2 pattern, 3 = counter
//   src_data    in   external source word
//   src_valid   in   external word valid
//   src_ready   out  external word accepted this cycle
//   fx2_flagc   in   endpoint not-full (1 = space)
//   fx2_fdata   out  FX2 data bus
//   fx2_faddr   out  FIFO address (FIFO_ADDR)
//   fx2_slwr    out  write strobe, active low
//   fx2_slrd    out  read strobe, held inactive
//   fx2_sloe    out  output enable, held inactive
//   fx2_pkt_end out  packet-end strobe, active low
//   busy        out  controller not idle
//   pkt_cnt     out  packets completed since reset (wraps)
// DATA_W must be 8 or 16; BYTE_SWAP only takes effect when DATA_W is 16.
// ---------------------------------------------------------------------------
module fx2_stream_in_ctrl
  import fx2_in_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          PKT_WORDS = 256,
  parameter logic [1:0]  FIFO_ADDR = EP6,
  parameter bit          BYTE_SWAP = 1'b0,
  parameter logic [15:0] PATTERN   = 16'hA55A
) (
  input  logic              fx2_ifclk,
  input  logic              reset_n,
  input  logic              tx_trigger,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic              fx2_flagc,
  output logic [DATA_W-1:0] fx2_fdata,
  output logic [1:0]        fx2_faddr,
  output logic              fx2_slwr,
  output logic              fx2_slrd,
  output logic              fx2_sloe,
  output logic              fx2_pkt_end,
  output logic              busy,
  output logic [15:0]       pkt_cnt
);

  localparam int              IDX_W    = (PKT_WORDS > 2) ? $clog2(PKT_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_WORDS - 1);
  localparam bit              DO_SWAP  = BYTE_SWAP && (DATA_W == 16);

  state_t              state;
  logic [1:0]          mode_q;
  logic [IDX_W-1:0]    word_idx;
  logic [DATA_W-1:0]   counter;
  logic                trig_sync;
  logic                run_req;
  logic                have_data;
  logic                last_word;
  logic                stop_empty;
  logic                wr_state;
  logic                wr;
  logic [DATA_W-1:0]   data_raw;

  // The button idles high, so the synchronizer resets to "not running".
  fx2_sync2 #(.RST_VAL(1'b1)) u_trig_sync (
    .fx2_ifclk (fx2_ifclk),
    .reset_n   (reset_n),
    .async_in  (tx_trigger),
    .sync_out  (trig_sync)
  );

  assign run_req   = ~trig_sync;
  assign have_data = (mode_q == MODE_EXT) ? src_valid : 1'b1;
  assign last_word = (word_idx == LAST_IDX);

  // A stop request at a packet boundary leaves WRITE without a write.
  assign stop_empty = (state == WRITE) && !run_req && (word_idx == '0);

`ifdef FX2_IN_SHORT_PKT_EN
  // A mid-packet stop moves to PKTEND without writing that cycle, so the
  // short packet is exactly what was written before the stop was seen.
  assign wr_state = ((state == WRITE) && run_req) || (state == DRAIN);
  assign fx2_pkt_end = !((state == PKTEND) && fx2_flagc);
`else
  assign wr_state = ((state == WRITE) && !stop_empty) || (state == DRAIN);
  assign fx2_pkt_end = 1'b1;
`endif

  assign wr        = wr_state && fx2_flagc && have_data;
  assign fx2_slwr  = ~wr;
  assign src_ready = wr && (mode_q == MODE_EXT);
  assign busy      = (state != IDLE);
  assign fx2_faddr = FIFO_ADDR;
  assign fx2_slrd  = 1'b1;
  assign fx2_sloe  = 1'b1;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    data_raw = counter;
    case (mode_q)
      MODE_EXT: data_raw = src_data;
      MODE_PAT: data_raw = PATTERN[DATA_W-1:0];
      default:  data_raw = counter;
    endcase
  end

  generate
    if (DO_SWAP) begin : g_swap
      assign fx2_fdata = {data_raw[7:0], data_raw[DATA_W-1:8]};
    end else begin : g_noswap
      assign fx2_fdata = data_raw;
    end
  endgenerate

  // The counter word on fdata only moves on an accepted write, so a stall
  // (flagc low or no source data) holds the bus steady.
  always_ff @(posedge fx2_ifclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      mode_q   <= MODE_CNT;
      word_idx <= '0;
      counter  <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (wr) begin
        counter <= counter + DATA_W'(1);
        if (last_word) begin
          word_idx <= '0;
          pkt_cnt  <= pkt_cnt + 16'd1;
        end else begin
          word_idx <= word_idx + IDX_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (run_req) begin
            state  <= WRITE;
            mode_q <= norm_mode(mode);
          end
        end

        WRITE: begin
          if (!run_req) begin
            if (word_idx == '0) state <= IDLE;
`ifdef FX2_IN_SHORT_PKT_EN
            else state <= PKTEND;
`else
            else if (wr && last_word) state <= IDLE;
            else state <= DRAIN;
`endif
          end
        end

        // A re-asserted run request only takes effect once the packet ends.
        DRAIN: begin
          if (wr && last_word) state <= run_req ? WRITE : IDLE;
        end

        PKTEND: begin
`ifdef FX2_IN_SHORT_PKT_EN
          // The strobe waits for space; the commit counts as a packet.
          if (fx2_flagc) begin
            word_idx <= '0;
            pkt_cnt  <= pkt_cnt + 16'd1;
            state    <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
